fsub_pipe: RTL and testbench

//  Pipelined subtractor: diff = a - b - bin, one 4-bit carry-lookahead nibble per stage.

---
 rtl/fsub_pipe.sv | 136 +++++++++++++
 tb/tb_fsub_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fsub_pipe.sv
// Pipelined subtractor: diff = a - b - bin, one 4-bit carry-lookahead nibble per stage.
// valid/ready on both ends, one op per cycle, latency WIDTH/4 cycles.
module fsub_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int STAGES = WIDTH / 4;

  // Handshake: a transfer happens on a posedge where valid & ready are both high.
  // Stage k accepts when it is empty or stage k+1 accepts this cycle; the
  // producer may not retract valid or change data until the transfer happens.

  // Stage registers. res_q[k] holds result nibbles 0..k with the still
  // unprocessed minuend nibbles above them; b_q[k] holds the remaining
  // subtrahend nibbles shifted down to bit 0.
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  // Carries are kept inverted (as borrows) so that the all-zero reset state
  // yields bout = 0 and overflow = 0.
  logic [STAGES-1:0] brw_q;
  logic              bmsb_q;

  logic [STAGES-1:0] ready;
  logic              rdy;

  logic [WIDTH-1:0]  src_res [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_c;

  logic [WIDTH-1:0]  nxt_res [STAGES];
  logic [WIDTH-1:0]  nxt_b   [STAGES];
  logic [STAGES-1:0] nxt_brw;
  logic              nxt_bmsb;
  logic [5:0]        nib;

  // Returns {carry into bit 3, carry out, sum[3:0]}.
  function automatic logic [5:0] nib_add(input logic [3:0] x, input logic [3:0] y,
                                         input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1, c2, c3, c4;
    g  = x & y;
    p  = x | y;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c3, c4, x ^ y ^ {c3, c2, c1, c0}};
  endfunction

  always_comb begin
    rdy = out_ready;
    ready = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy = rdy | ~valid_q[k];
      ready[k] = rdy;
    end
  end

  always_comb begin
    src_res[0] = a;
    src_b[0]   = b;
    src_v[0]   = in_valid;
    src_c[0]   = ~bin;
    for (int k = 1; k < STAGES; k++) begin
      src_res[k] = res_q[k-1];
      src_b[k]   = b_q[k-1];
      src_v[k]   = valid_q[k-1];
      src_c[k]   = ~brw_q[k-1];
    end
  end

  always_comb begin
    nib      = '0;
    nxt_brw  = '0;
    nxt_bmsb = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      nib = nib_add(src_res[k][4*k +: 4], ~src_b[k][3:0], src_c[k]);
      nxt_res[k]          = src_res[k];
      nxt_res[k][4*k +: 4] = nib[3:0];
      nxt_b[k]            = src_b[k] >> 4;
      nxt_brw[k]          = ~nib[4];
      nxt_bmsb            = ~nib[5];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      brw_q   <= '0;
      bmsb_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_q[k] <= src_v[k];
          // Data only moves with a valid op so outputs hold through bubbles.
          if (src_v[k]) begin
            res_q[k]   <= nxt_res[k];
            b_q[k]     <= nxt_b[k];
            brw_q[k]   <= nxt_brw[k];
          end
        end
      end
      if (ready[STAGES-1] && src_v[STAGES-1]) begin
        bmsb_q <= nxt_bmsb;
      end
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[STAGES-1];
  assign diff      = res_q[STAGES-1];
  assign bout      = brw_q[STAGES-1];
  assign overflow  = brw_q[STAGES-1] ^ bmsb_q;

endmodule

// File: tb/tb_fsub_pipe.sv
// Directed bench for fsub_pipe (WIDTH=8): hand-computed vectors, backpressure,
// random streaming against a reference model, and asynchronous reset mid-flight.
module tb_fsub_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
  logic       overflow;

  int checks;
  int failures;
  int n_pop;
  int pop_base;
  logic [9:0] exp_q[$];

  fsub_pipe #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .overflow (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {diff, bout, overflow} from plain 9-bit arithmetic
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] f;
    logic       ovf;
    f   = {1'b0, x} - {1'b0, y} - {8'd0, c};
    ovf = (x[7] ^ y[7]) & (f[7] ^ x[7]);
    return {f[7:0], f[8], ovf};
  endfunction

  // scoreboard: sample away from the active edge
  always @(negedge clk) begin
    if (rst && in_valid && in_ready) exp_q.push_back(model(a, b, bin));
    if (rst && out_valid && out_ready) begin
      n_pop++;
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else check("sb_result", 32'({diff, bout, overflow}), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks; all called at posedge+1
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic acc;
    acc = 1'b0;
    a = x; b = y; bin = c; in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic run_vec(input logic [7:0] x, input logic [7:0] y, input logic c,
                         input logic [7:0] ed, input logic eb, input logic eo);
    send(x, y, c);
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("vec_out_valid", 32'(out_valid), 32'd1);
    check("vec_diff", 32'(diff), 32'(ed));
    check("vec_bout", 32'(bout), 32'(eb));
    check("vec_overflow", 32'(overflow), 32'(eo));
  endtask

  task automatic drain(input int expect_pops);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("pop_count", 32'(n_pop - pop_base), 32'(expect_pops));
    pop_base = n_pop;
  endtask

  initial begin
    logic done;
    checks = 0; failures = 0; n_pop = 0; pop_base = 0;
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    done = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // basic op with latency: accepted at edge N, valid after edge N+1
    send(8'h35, 8'h12, 1'b0);
    check("lat_edge_n", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge_n1", 32'(out_valid), 32'd1);
    check("basic_diff", 32'(diff), 32'h23);
    check("basic_bout", 32'(bout), 32'd0);
    check("basic_overflow", 32'(overflow), 32'd0);
    drain(1);

    // borrow, wrap, inter-nibble borrow, signed overflow
    run_vec(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_vec(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    run_vec(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_vec(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_vec(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_vec(8'hA0, 8'h0B, 1'b1, 8'h94, 1'b0, 1'b0);
    drain(6);

    // backpressure: two accepts fill the pipe, third op waits
    out_ready = 1'b0;
    send(8'h35, 8'h12, 1'b0);
    send(8'h10, 8'h01, 1'b0);
    a = 8'hA0; b = 8'h0B; bin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_diff_held", 32'({diff, bout, overflow}), 32'({8'h23, 1'b0, 1'b0}));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(8'hA0, 8'h0B, 1'b1);
    drain(3);

    // streaming with random backpressure
    fork
      begin
        for (int i = 0; i < 100; i++)
          send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain(100);

    // asynchronous reset with two ops in flight
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0);
    send(8'h9C, 8'h21, 1'b1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_outputs", 32'({diff, bout, overflow}), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    pop_base = n_pop;
    @(posedge clk); #1;
    check("post_rst_empty", 32'(out_valid), 32'd0);
    run_vec(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
